// File: rtl/config_loader.sv
// config_loader: configuration-bus initiator for the CGRA fabric.
//
// Accepts a byte stream over a valid/ready handshake. The stream carries a 16-bit
// record count N, followed by N 8-byte records {addr[31:0], data[31:0]}, all MSB-first.
// Each record is driven onto config_addr/config_data for WRITE_CYCLES cycles. Between
// writes the address is parked on IDLE_ADDR, which no tile decodes.
//
// Ports:
//   clk          fabric clock, rising edge
//   reset        synchronous active-low reset
//   start        begin a load (sampled only in IDLE)
//   in_data      stream byte
//   in_valid     in_data valid this cycle
//   in_ready     byte accepted when in_valid && in_ready
//   config_addr  {config type, tile_id} broadcast to all tiles
//   config_data  configuration word broadcast to all tiles
//   config_write high while a record is driven
//   busy         high in every state except IDLE
//   done         one-cycle pulse when a load completes
//   records_done records written in the current/last load
module config_loader #(
    parameter logic [31:0] IDLE_ADDR    = 32'h0000_0000,
    parameter int unsigned WRITE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] config_addr,
    output logic [31:0] config_data,
    output logic        config_write,
    output logic        busy,
    output logic        done,
    output logic [15:0] records_done
);

    typedef enum logic [2:0] {
        StIdle,
        StHdr0,
        StHdr1,
        StRec,
        StWrite,
        StDone
    } state_e;

    localparam logic [7:0] LastWrCycle = 8'(WRITE_CYCLES - 1);

    state_e      state_q;
    logic [15:0] num_records_q;
    logic [2:0]  byte_idx_q;
    logic [55:0] asm_q;       // first seven bytes of the record being assembled
    logic [7:0]  wr_cnt_q;
    logic        xfer;
    logic [63:0] rec_full;

    assign xfer     = in_valid && in_ready;
    assign rec_full = {asm_q, in_data};

    // All outputs are registered and updated on the transition into the state that owns them.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= StIdle;
            num_records_q <= 16'd0;
            byte_idx_q    <= 3'd0;
            asm_q         <= 56'd0;
            wr_cnt_q      <= 8'd0;
            in_ready      <= 1'b0;
            config_addr   <= IDLE_ADDR;
            config_data   <= 32'd0;
            config_write  <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            records_done  <= 16'd0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q      <= StHdr0;
                        in_ready     <= 1'b1;
                        busy         <= 1'b1;
                        records_done <= 16'd0;
                    end
                end
                StHdr0: begin
                    if (xfer) begin
                        num_records_q[15:8] <= in_data;
                        state_q             <= StHdr1;
                    end
                end
                StHdr1: begin
                    if (xfer) begin
                        num_records_q[7:0] <= in_data;
                        byte_idx_q         <= 3'd0;
                        if ({num_records_q[15:8], in_data} == 16'd0) begin
                            state_q  <= StDone;
                            in_ready <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            state_q <= StRec;
                        end
                    end
                end
                StRec: begin
                    if (xfer) begin
                        asm_q      <= rec_full[55:0];
                        byte_idx_q <= byte_idx_q + 3'd1;
                        if (byte_idx_q == 3'd7) begin
                            state_q      <= StWrite;
                            in_ready     <= 1'b0;
                            config_write <= 1'b1;
                            config_addr  <= rec_full[63:32];
                            config_data  <= rec_full[31:0];
                            wr_cnt_q     <= 8'd0;
                        end
                    end
                end
                StWrite: begin
                    if (wr_cnt_q == LastWrCycle) begin
                        records_done <= records_done + 16'd1;
                        config_write <= 1'b0;
                        config_addr  <= IDLE_ADDR;
                        if (records_done + 16'd1 == num_records_q) begin
                            state_q <= StDone;
                            done    <= 1'b1;
                        end else begin
                            state_q    <= StRec;
                            in_ready   <= 1'b1;
                            byte_idx_q <= 3'd0;
                        end
                    end else begin
                        wr_cnt_q <= wr_cnt_q + 8'd1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
